// File: rtl/sync_input_cond.sv
// -----------------------------------------------------------------------------
// sync_input_cond
//   Two-channel input conditioner. Each raw asynchronous input is passed
//   through a SYNC_STAGES-deep synchronizer and then debounced by a small
//   per-channel state machine. A new level is accepted only after
//   DEBOUNCE_CYCLES consecutive synchronized samples agree; shorter excursions
//   are aborted and counted in a shared saturating glitch counter.
//
// Parameters
//   SYNC_STAGES      synchronizer depth per channel (>= 2)
//   DEBOUNCE_CYCLES  consecutive samples needed to accept a level (>= 2)
//
// Ports
//   clk         single clock domain
//   rst_n       asynchronous active-low reset
//   a_raw/b_raw raw asynchronous inputs
//   glitch_clr  synchronous clear of glitch_cnt (wins over increments)
//   a/b         registered debounced levels
//   a_rise/b_rise  registered one-cycle pulse on each accepted 0->1 change
//   glitch_cnt  aborted transitions on both channels, saturating at 255
// -----------------------------------------------------------------------------
module sync_input_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_raw,
  input  logic       b_raw,
  input  logic       glitch_clr,
  output logic       a,
  output logic       b,
  output logic       a_rise,
  output logic       b_rise,
  output logic [7:0] glitch_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_PEND_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_PEND_LO   = 2'd3
  } state_e;

  // Channel 0 is A, channel 1 is B.
  logic [1:0]             raw_s;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [1:0]             s_s;
  state_e                 state_q [2];
  state_e                 state_d [2];
  logic [CW-1:0]          cnt_q [2];
  logic [CW-1:0]          cnt_d [2];
  logic [1:0]             lvl_q, lvl_d;
  logic [1:0]             rise_q, rise_d;
  logic [1:0]             glitch_s;
  logic [7:0]             glitch_cnt_q, glitch_cnt_d;
  logic [8:0]             glitch_sum_s;

  assign raw_s = {b_raw, a_raw};
  assign s_s   = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

  // Synchronizer chains: shift raw input toward the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw_s[ch]};
      end
    end
  end

  // Debounce next-state logic; outputs only change on entry to a stable state.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch]  = state_q[ch];
      cnt_d[ch]    = cnt_q[ch];
      lvl_d[ch]    = lvl_q[ch];
      rise_d[ch]   = 1'b0;
      glitch_s[ch] = 1'b0;
      case (state_q[ch])
        ST_STABLE_LO: begin
          if (s_s[ch]) begin
            state_d[ch] = ST_PEND_HI;
            cnt_d[ch]   = CNT_ONE;
          end else begin
            state_d[ch] = ST_STABLE_LO;
          end
        end
        ST_PEND_HI: begin
          if (!s_s[ch]) begin
            state_d[ch]  = ST_STABLE_LO;
            glitch_s[ch] = 1'b1;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_STABLE_HI;
            lvl_d[ch]   = 1'b1;
            rise_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
          end
        end
        ST_STABLE_HI: begin
          if (!s_s[ch]) begin
            state_d[ch] = ST_PEND_LO;
            cnt_d[ch]   = CNT_ONE;
          end else begin
            state_d[ch] = ST_STABLE_HI;
          end
        end
        ST_PEND_LO: begin
          if (s_s[ch]) begin
            state_d[ch]  = ST_STABLE_HI;
            glitch_s[ch] = 1'b1;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = ST_STABLE_LO;
            lvl_d[ch]   = 1'b0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
          end
        end
        default: begin
          state_d[ch] = ST_STABLE_LO;
          lvl_d[ch]   = 1'b0;
        end
      endcase
    end
  end

  // Glitch counter next value: up to +2 per cycle, saturating, clear wins.
  always_comb begin
    glitch_sum_s = {1'b0, glitch_cnt_q} + {8'd0, glitch_s[0]} + {8'd0, glitch_s[1]};
    if (glitch_clr) begin
      glitch_cnt_d = 8'd0;
    end else if (glitch_sum_s > 9'd255) begin
      glitch_cnt_d = 8'd255;
    end else begin
      glitch_cnt_d = glitch_sum_s[7:0];
    end
  end

  // Debounce state, counters, registered outputs and glitch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ST_STABLE_LO;
        cnt_q[ch]   <= '0;
      end
      lvl_q        <= 2'b00;
      rise_q       <= 2'b00;
      glitch_cnt_q <= 8'd0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      lvl_q        <= lvl_d;
      rise_q       <= rise_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign a          = lvl_q[0];
  assign b          = lvl_q[1];
  assign a_rise     = rise_q[0];
  assign b_rise     = rise_q[1];
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_sync_input_cond.sv
// -----------------------------------------------------------------------------
// tb_sync_input_cond
//   Scoreboard bench: when stimulus is driven, the expected output values are
//   queued together with the clock edge at which they must hold; a negedge
//   monitor pops and compares each entry when that edge has been reached.
//   A second instance with SYNC_STAGES=3, DEBOUNCE_CYCLES=2 covers the
//   parameterised latency.
// -----------------------------------------------------------------------------
module tb_sync_input_cond;

  logic       clk;
  logic       rst_n;
  logic       a_raw, b_raw, glitch_clr;
  logic       a, b, a_rise, b_rise;
  logic [7:0] glitch_cnt;

  logic       pa_raw, pb_raw, p_glitch_clr;
  logic       pa, pb, pa_rise, pb_rise;
  logic [7:0] p_glitch_cnt;

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    int    at;
    int    sel;
    int    exp;
    string tag;
  } exp_t;

  exp_t sb_q[$];

  sync_input_cond dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_raw      (a_raw),
    .b_raw      (b_raw),
    .glitch_clr (glitch_clr),
    .a          (a),
    .b          (b),
    .a_rise     (a_rise),
    .b_rise     (b_rise),
    .glitch_cnt (glitch_cnt)
  );

  sync_input_cond #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_raw      (pa_raw),
    .b_raw      (pb_raw),
    .glitch_clr (p_glitch_clr),
    .a          (pa),
    .b          (pb),
    .a_rise     (pa_rise),
    .b_rise     (pb_rise),
    .glitch_cnt (p_glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: value k at a negedge means k rising edges have occurred.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] obs_of(input int sel);
    case (sel)
      0:       obs_of = {15'd0, a};
      1:       obs_of = {15'd0, b};
      2:       obs_of = {15'd0, a_rise};
      3:       obs_of = {15'd0, b_rise};
      4:       obs_of = {8'd0, glitch_cnt};
      5:       obs_of = {15'd0, pa};
      6:       obs_of = {15'd0, pa_rise};
      7:       obs_of = {8'd0, p_glitch_cnt};
      8:       obs_of = {15'd0, pb};
      default: obs_of = 16'hFFFF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input int at, input int exp);
    exp_t e;
    e.at = at; e.sel = sel; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_range(input string tag, input int sel, input int from, input int to, input int exp);
    for (int k = from; k <= to; k++) push_exp(tag, sel, k, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation whose edge has been reached.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].at <= cyc) begin
        chk_val(sb_q[i].tag, obs_of(sb_q[i].sel), sb_q[i].exp[15:0]);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; a_raw = 1'b0; b_raw = 1'b0; glitch_clr = 1'b0;
    pa_raw = 1'b0; pb_raw = 1'b0; p_glitch_clr = 1'b0;
    tick(3);
    chk_val("rst_a", {15'd0, a}, 16'd0);
    chk_val("rst_b", {15'd0, b}, 16'd0);
    chk_val("rst_rise", {14'd0, a_rise, b_rise}, 16'd0);
    chk_val("rst_glitch", {8'd0, glitch_cnt}, 16'd0);
    chk_val("rst_p_a", {15'd0, pa}, 16'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean rise on A: accepted at edge 6 with a one-cycle pulse.
    t0 = cyc; a_raw = 1'b1;
    push_range("rise_a_low", 0, t0 + 1, t0 + 5, 0);
    push_range("rise_pulse_early", 2, t0 + 1, t0 + 5, 0);
    push_exp("rise_a_high", 0, t0 + 6, 1);
    push_exp("rise_pulse", 2, t0 + 6, 1);
    push_exp("rise_pulse_end", 2, t0 + 7, 0);
    push_exp("rise_glitch", 4, t0 + 7, 0);
    tick(9);

    // Accepted fall on A: at edge 6, never a rise pulse.
    t0 = cyc; a_raw = 1'b0;
    push_range("fall_a_high", 0, t0 + 1, t0 + 5, 1);
    push_exp("fall_a_low", 0, t0 + 6, 0);
    push_range("fall_no_pulse", 2, t0 + 1, t0 + 8, 0);
    push_exp("fall_glitch", 4, t0 + 8, 0);
    tick(9);

    a_raw = 1'b1;
    tick(10);

    // Two-cycle low excursion aborts PEND_LO and counts a glitch.
    t0 = cyc; a_raw = 1'b0;
    push_range("pendlo_a_high", 0, t0 + 1, t0 + 10, 1);
    push_range("pendlo_no_pulse", 2, t0 + 1, t0 + 10, 0);
    push_exp("pendlo_glitch_pre", 4, t0 + 4, 0);
    push_exp("pendlo_glitch", 4, t0 + 5, 1);
    tick(2);
    a_raw = 1'b1;
    tick(8);

    a_raw = 1'b0;
    tick(10);

    // Bounce on B: 3 high / 5 low, three times.
    t0 = cyc;
    push_range("bounce_b_low", 1, t0 + 1, t0 + 28, 0);
    push_range("bounce_no_pulse", 3, t0 + 1, t0 + 28, 0);
    for (int r = 0; r < 3; r++) begin
      b_raw = 1'b1; tick(3);
      b_raw = 1'b0; tick(5);
    end
    push_exp("bounce_glitch", 4, cyc + 1, 4);
    tick(5);

    // Preload to 254 with simultaneous two-cycle excursions (+2 each).
    for (int r = 0; r < 125; r++) begin
      a_raw = 1'b1; b_raw = 1'b1; tick(2);
      a_raw = 1'b0; b_raw = 1'b0; tick(6);
    end
    push_exp("preload_254", 4, cyc + 1, 254);
    tick(2);

    // Simultaneous glitch from 254: saturates at 255.
    t0 = cyc; a_raw = 1'b1; b_raw = 1'b1;
    push_exp("sat_before", 4, t0 + 4, 254);
    push_exp("sat_dual", 4, t0 + 5, 255);
    push_exp("sat_dual_hold", 4, t0 + 8, 255);
    tick(2);
    a_raw = 1'b0; b_raw = 1'b0;
    tick(7);

    t0 = cyc; a_raw = 1'b1;
    push_exp("sat_single", 4, t0 + 5, 255);
    push_exp("sat_single_hold", 4, t0 + 8, 255);
    tick(2);
    a_raw = 1'b0;
    tick(7);

    // Clear in the same cycle as a glitch: clear wins.
    t0 = cyc; a_raw = 1'b1;
    push_exp("clr_before", 4, t0 + 4, 255);
    push_exp("clr_vs_glitch", 4, t0 + 5, 0);
    push_exp("clr_hold", 4, t0 + 8, 0);
    tick(2);
    a_raw = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    tick(6);

    // Reset three cycles into PEND_HI; raw held high through release.
    t0 = cyc; a_raw = 1'b1;
    tick(5);
    #1 rst_n = 1'b0;
    #1;
    chk_val("midrst_a", {15'd0, a}, 16'd0);
    chk_val("midrst_rise", {14'd0, a_rise, b_rise}, 16'd0);
    chk_val("midrst_glitch", {8'd0, glitch_cnt}, 16'd0);
    tick(2);
    rst_n = 1'b1;
    t0 = cyc;
    push_range("midrst_a_low", 0, t0 + 1, t0 + 5, 0);
    push_exp("midrst_a_high", 0, t0 + 6, 1);
    push_exp("midrst_pulse", 2, t0 + 6, 1);
    push_exp("midrst_pulse_end", 2, t0 + 7, 0);
    push_exp("midrst_glitch_after", 4, t0 + 7, 0);
    tick(9);

    // SYNC_STAGES=3, DEBOUNCE_CYCLES=2: rise at edge 5.
    t0 = cyc; pa_raw = 1'b1;
    push_range("p_rise_low", 5, t0 + 1, t0 + 4, 0);
    push_exp("p_rise_high", 5, t0 + 5, 1);
    push_exp("p_rise_pulse", 6, t0 + 5, 1);
    push_exp("p_rise_pulse_end", 6, t0 + 6, 0);
    tick(8);

    // One-cycle pulse on channel B of the small instance: glitch.
    t0 = cyc; pb_raw = 1'b1;
    push_exp("p_glitch_pre", 7, t0 + 4, 0);
    push_exp("p_glitch", 7, t0 + 5, 1);
    push_range("p_b_low", 8, t0 + 1, t0 + 8, 0);
    tick(1);
    pb_raw = 1'b0;
    tick(8);

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick(1);
    chk_val("sb_drain", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_input_cond.md
# sync_input_cond

Two-channel input conditioner placed directly upstream of the synchronous Moore sequence detector. It takes raw, asynchronous, possibly bouncing inputs `a_raw`/`b_raw`, synchronizes each through a flop chain, debounces each with a per-channel state machine, and drives clean levels `a`/`b` that go straight into the detector's `a`/`b` inputs. It also provides one-cycle edge pulses and a saturating glitch counter for diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth per channel; legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive synchronized samples needed to accept a new level; legal values are 2 or more.
- `clk`  in  1  single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_raw`  in  1  raw asynchronous input, channel A.
- `b_raw`  in  1  raw asynchronous input, channel B.
- `glitch_clr`  in  1  synchronous clear of `glitch_cnt`.
- `a`  out  1  debounced level, channel A; registered.
- `b`  out  1  debounced level, channel B; registered.
- `a_rise`  out  1  one-cycle pulse, asserted in the same cycle `a` goes 0→1.
- `b_rise`  out  1  one-cycle pulse, asserted in the same cycle `b` goes 0→1.
- `glitch_cnt`  out  8  count of aborted transitions, both channels combined; saturates at 255.

## Operation
- **Synchronizer.** Each channel has a `SYNC_STAGES`-deep flop chain. `s` denotes the last stage. Only `s` feeds the FSM.
- **Per-channel FSM states:** STABLE_LO, PEND_HI, STABLE_HI, PEND_LO. Each channel has a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
- **STABLE_LO**
  - `s`=1 → PEND_HI, `cnt`=1.
  - Otherwise hold.
- **PEND_HI**
  - `s`=0 → STABLE_LO; the channel records a glitch.
  - `s`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → STABLE_HI; output goes to 1 and the rise pulse goes to 1.
  - Otherwise `cnt`++.
- **STABLE_HI**
  - `s`=0 → PEND_LO, `cnt`=1.
  - Otherwise hold.
- **PEND_LO**
  - `s`=1 → STABLE_HI; the channel records a glitch.
  - `s`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → STABLE_LO; output goes to 0. There is no fall pulse.
  - Otherwise `cnt`++.
- **Output levels.** The output level changes only on entry to STABLE_HI or STABLE_LO. During PEND states the output keeps its previous stable value.
- **Rise pulses.** `a_rise`/`b_rise` are high for exactly one cycle per accepted rising transition, then return to 0.
- **Glitch counter.**
  - Increments by 1 for each glitch recorded in a cycle: +2 if both channels abort in the same cycle.
  - Saturates at 255 and never wraps; 254 plus two glitches gives 255.
  - `glitch_clr`=1 forces 0 and takes priority over increments in the same cycle.
- **Channel independence.** The channels are fully independent. Simultaneous activity on both changes neither channel's timing.

## Timing
- **Reset values** (asynchronous assertion, immediate): all synchronizer flops 0, both FSMs STABLE_LO, `cnt`=0, `a`=`b`=0, `a_rise`=`b_rise`=0, `glitch_cnt`=0.
- **Acceptance latency.** Number the first rising `clk` edge that samples a steady raw change as edge 1. The output changes at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`. With defaults that is edge 6.
- **Minimum accepted pulse width.** A raw level must be held for at least `DEBOUNCE_CYCLES` consecutive synchronized samples. Shorter excursions are rejected and counted as a glitch. Excursions shorter than one clock may be missed entirely, which is legal.
- **Reset mid-operation.** An in-progress PEND is discarded with no glitch counted. If a raw input is held high through reset release, it is treated as a fresh 0→1 change: `a` rises at the latency above, with `a_rise` pulsed.
- **Downstream interface.** `a` and `b` are registered outputs, so the detector sees them one edge later with no combinational path from the raw inputs.

## Test plan
- **Reset and clean rise.** Reset, release, then hold `a_raw`=1 from edge 1. Required: `a`=0 through edge 5; `a`=1 and `a_rise`=1 at edge 6; `a_rise`=0 at edge 7; `glitch_cnt`=0.
- **Bounce rejection.** `b_raw` high for 3 cycles, low for 5, repeated 3 times. Required: `b` stays 0, `b_rise` never asserts, `glitch_cnt`=3.
- **Accepted fall.** With `a`=1, drop `a_raw` to 0 and hold. Required: `a`=0 at edge 6; no pulse on `a_rise`; PEND_LO aborts counted when the low excursion is only 2 cycles.
- **Simultaneous glitches and saturation.** Preload `glitch_cnt`=254 via repeated glitches, then give both channels a 2-cycle high excursion in the same cycles. Required: `glitch_cnt`=255. A further glitch keeps it at 255. `glitch_clr` asserted in the same cycle as a glitch gives 0.
- **Reset mid-PEND.** Assert `rst_n`=0 three cycles into a PEND_HI on channel A. Required: all outputs 0 immediately and `glitch_cnt` unchanged (0). With `a_raw` still 1 after release, `a` rises at edge 6 with `a_rise`.
- **Parameter sweep.** `SYNC_STAGES`=3, `DEBOUNCE_CYCLES`=2, clean rise. Required: `a` rises at edge 5; a 1-cycle synchronized pulse is rejected and counted as a glitch.
